control_step_sequencer: RTL
===========================

Name: control_step_sequencer

Overview:
Parametrised control-step generator for the multi-cycle CPU datapath.
- Produces one-hot control steps T0..T(MAX_STEPS-1), with T0–T2 used for fetch.
- Supports a variable per-instruction step count, memory stall, halt/resume and interrupt service at instruction boundaries.
- The control unit's signal-assertion logic decodes `step_onehot` together with the opcode; this block owns only sequencing.

Parameters:
- MAX_STEPS, 8, maximum control steps per instruction including fetch; legal range 4..16.
- INT_STEPS, 3, number of steps in the interrupt-service sequence; legal range 1..MAX_STEPS.
- LEN_W, 5, width of the `inst_len` input.
- WDOG_LIMIT, 15, maximum consecutive stall cycles; used only with STEP_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stop  in  1  halt request; latched as sticky until honoured.
- start  in  1  resume request; single-cycle pulse, honoured only in HALT.
- mem_stall  in  1  memory not ready; the current step is held.
- inst_len  in  LEN_W  total step count for the current opcode, from the decoder; sampled at end of T2.
- irq  in  1  interrupt request, level.
- irq_en  in  1  interrupt enable.
- step_onehot  out  MAX_STEPS  one-hot current step; all zero in RST and HALT.
- step_idx  out  $clog2(MAX_STEPS)  binary current step.
- run  out  1  high in RUN and INT.
- clr  out  1  datapath clear, high in RST only.
- fetch  out  1  high when state is RUN and step_idx <= 2.
- instr_done  out  1  high during the final step cycle of an instruction when mem_stall=0.
- int_active  out  1  high in INT.
- int_ack  out  1  high for the first INT cycle only.
- fault  out  1  watchdog fault; sticky until reset.

Behaviour:
State machine: RST, RUN, INT, HALT.
- **Reset asserted:**
  - State goes to RST.
  - step_idx=0, step_onehot=0, run=0, clr=1, fetch=0, instr_done=0, int_active=0, int_ack=0, fault=0.
  - Length register=MAX_STEPS; stop_pending=0.
- **Reset mid-instruction:** aborts immediately with no completion pulse.
- **RST:** one cycle after reset deasserts, then RUN with step 0.
- **RUN, step advance:** step_idx increments by one per cycle when mem_stall=0; when mem_stall=1, all state and outputs are held.
- **RUN, end of T2** (step_idx==2 and mem_stall=0): latch len = clamp(inst_len, 3, MAX_STEPS).
  - Values below 3 become 3; values above MAX_STEPS become MAX_STEPS.
- **RUN, final step** (step_idx==len-1 and mem_stall=0): instr_done=1 that cycle (Mealy output). Next state by priority:
  1. stop_pending → HALT, and clear stop_pending.
  2. irq && irq_en → INT, step 0.
  3. Otherwise RUN, step 0.
- **stop:** sets stop_pending in any state except HALT. A stop asserted during the final step is honoured at that same boundary.
- **INT:**
  - Steps 0..INT_STEPS-1 with step_onehot driven; int_ack=1 in the first cycle only.
  - mem_stall holds the step as in RUN.
  - After the last INT step: HALT if stop_pending, else RUN step 0.
  - irq is not re-sampled inside INT.
- **HALT:**
  - run=0, step_onehot=0.
  - start=1 → RUN step 0. If start and stop are both high in the same cycle, the block stays in HALT.
  - mem_stall and irq are ignored.
- **Step width:** step_idx never reaches MAX_STEPS; there is no wrap except via the boundary return to 0.
- **Outputs:** all are registered except instr_done, fetch and int_ack, which are decoded from registered state plus mem_stall.

Optional Feature:
STEP_WATCHDOG_EN
- **With the macro defined:**
  - A counter tracks consecutive mem_stall cycles in RUN or INT and is cleared by any non-stalled cycle.
  - When the count reaches WDOG_LIMIT: fault=1 (sticky), state → HALT, stop_pending cleared.
  - start cannot exit HALT while fault=1; only reset clears it.
- **Without the macro:** stalls are unbounded, fault is tied to 0 and no counter is synthesised.

Test Plan:
- Reset, then release; inst_len=5, no stall → clr=1 for one cycle, then step_onehot 0x01,0x02,0x04,0x08,0x10, instr_done in the 5th cycle, back to 0x01.
- inst_len=1, then inst_len=20 with MAX_STEPS=8 → instructions of 3 and 8 steps respectively.
- mem_stall=1 for 4 cycles at T1 → step_idx holds at 1 for 4 cycles, fetch stays 1, total instruction length +4 cycles.
- irq=1, irq_en=1 during T3 of a 4-step instruction → after instr_done: int_ack for one cycle and 3 INT steps, then RUN step 0; with irq_en=0 there is no INT.
- stop pulse at T1 with irq also pending → HALT after instr_done (stop beats irq); start+stop together keeps HALT; start alone → RUN step 0.
- STEP_WATCHDOG_EN, WDOG_LIMIT=15: mem_stall held 15 cycles → fault=1, HALT, start ignored; reset clears fault; 14-cycle stall produces no fault.

Source files
------------

// File: rtl/control_step_sequencer.sv
// Control-step sequencer for the multi-cycle CPU: one-hot T-steps, variable length,
// memory stall, halt/resume and interrupt entry at instruction boundaries.
// Optional stall watchdog is enabled by defining STEP_WATCHDOG_EN.
module control_step_sequencer #(
    parameter int MAX_STEPS  = 8,
    parameter int INT_STEPS  = 3,
    parameter int LEN_W      = 5,
    parameter int WDOG_LIMIT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stop,
    input  logic                         start,
    input  logic                         mem_stall,
    input  logic [LEN_W-1:0]             inst_len,
    input  logic                         irq,
    input  logic                         irq_en,
    output logic [MAX_STEPS-1:0]         step_onehot,
    output logic [$clog2(MAX_STEPS)-1:0] step_idx,
    output logic                         run,
    output logic                         clr,
    output logic                         fetch,
    output logic                         instr_done,
    output logic                         int_active,
    output logic                         int_ack,
    output logic                         fault
);

    localparam int IDX_W  = $clog2(MAX_STEPS);
    localparam int LEN_CW = $clog2(MAX_STEPS + 1);

    if (MAX_STEPS < 4 || MAX_STEPS > 16 || INT_STEPS < 1 || INT_STEPS > MAX_STEPS ||
        WDOG_LIMIT < 1) begin : g_bad_params
        $error("control_step_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_RST,
        ST_RUN,
        ST_INT,
        ST_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [LEN_CW-1:0] len_q, len_d;
    logic              stop_pending_q, stop_pending_d;
    logic [LEN_CW-1:0] len_clamped;
    logic [LEN_CW-1:0] len_eff;
    logic              last_step;
    logic              last_int_step;
    logic              start_blocked;

`ifdef STEP_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              fault_q, fault_d;
    assign start_blocked = fault_q;
    assign fault         = fault_q;
`else
    assign start_blocked = 1'b0;
    assign fault         = 1'b0;
`endif

    always_comb begin
        if (int'(inst_len) < 3) begin
            len_clamped = LEN_CW'(3);
        end else if (int'(inst_len) > MAX_STEPS) begin
            len_clamped = LEN_CW'(MAX_STEPS);
        end else begin
            len_clamped = LEN_CW'(inst_len);
        end
    end

    // At T2 the decoder's length is not yet latched, so a 3-step instruction ends on it.
    assign len_eff       = (int'(step_q) == 2) ? len_clamped : len_q;
    assign last_step     = (int'(step_q) + 1 == int'(len_eff));
    assign last_int_step = (int'(step_q) == INT_STEPS - 1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d        = state_q;
        step_d         = step_q;
        len_d          = len_q;
        stop_pending_d = stop_pending_q | (stop & (state_q != ST_HALT));
`ifdef STEP_WATCHDOG_EN
        wdog_d         = '0;
        fault_d        = fault_q;
`endif

        case (state_q)
            ST_RST: begin
                state_d = ST_RUN;
                step_d  = '0;
            end
            ST_RUN: begin
                if (!mem_stall) begin
                    if (int'(step_q) == 2) len_d = len_clamped;
                    if (last_step) begin
                        step_d = '0;
                        if (stop_pending_d) begin
                            state_d        = ST_HALT;
                            stop_pending_d = 1'b0;
                        end else if (irq && irq_en) begin
                            state_d = ST_INT;
                        end
                    end else begin
                        step_d = step_q + IDX_W'(1);
                    end
                end
            end
            ST_INT: begin
                if (!mem_stall) begin
                    if (last_int_step) begin
                        step_d = '0;
                        if (stop_pending_d) begin
                            state_d        = ST_HALT;
                            stop_pending_d = 1'b0;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        step_d = step_q + IDX_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (start && !stop && !start_blocked) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = ST_RST;
                step_d  = '0;
            end
        endcase

`ifdef STEP_WATCHDOG_EN
        // Stall counting overrides the normal hold: a stuck memory forces a sticky halt.
        if ((state_q == ST_RUN || state_q == ST_INT) && mem_stall) begin
            if (int'(wdog_q) == WDOG_LIMIT - 1) begin
                fault_d        = 1'b1;
                state_d        = ST_HALT;
                step_d         = '0;
                stop_pending_d = 1'b0;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RST;
            step_q         <= '0;
            len_q          <= LEN_CW'(MAX_STEPS);
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            len_q          <= len_d;
            stop_pending_q <= stop_pending_d;
        end
    end

`ifdef STEP_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end
`endif

    always_comb begin
        step_onehot = '0;
        if (state_q == ST_RUN || state_q == ST_INT) step_onehot[step_q] = 1'b1;
    end

    assign step_idx   = step_q;
    assign run        = (state_q == ST_RUN) || (state_q == ST_INT);
    assign clr        = (state_q == ST_RST);
    assign int_active = (state_q == ST_INT);
    assign fetch      = (state_q == ST_RUN) && (int'(step_q) <= 2);
    assign instr_done = (state_q == ST_RUN) && last_step && !mem_stall;
    assign int_ack    = (state_q == ST_INT) && (step_q == '0) && !mem_stall;

endmodule
